div_iter_nbit: RTL

DIV_ITER_NBIT -- requirements
Module: div_iter_nbit

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_iter_nbit_if.sv | 33 +++
 rtl/div_step.sv | 35 +++
 rtl/div_iter_nbit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_e    : FSM state encoding (IDLE, CALC, DONE), also exported on the debug port.
//   DIV_*          : legal configuration bounds.
//   div_cfg_legal  : constant function that checks a SIZE/STEP pairing at elaboration.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam int DIV_MIN_SIZE = 8;
    localparam int DIV_MAX_SIZE = 64;

    // STEP may retire 1, 2 or 4 quotient bits per cycle and must divide SIZE evenly.
    function automatic bit div_cfg_legal(input int size, input int step);
        bit step_ok;
        step_ok = (step == 1) || (step == 2) || (step == 4);
        return step_ok && (size >= DIV_MIN_SIZE) && (size <= DIV_MAX_SIZE)
               && ((size % step) == 0);
    endfunction

endpackage

// File: rtl/div_iter_nbit_if.sv
// Request/result bundle of the iterative divider.
//   start, is_signed, dividend, divisor : request side (driven by the master)
//   ready, valid, error, quotient, remainder : response side (driven by the divider)
//
// Handshake: a request is accepted on a rising clk edge where start=1 and
// ready=1; operands and is_signed are sampled on that same edge only. valid is a
// one-cycle pulse with no backpressure; quotient/remainder/error are meaningful
// while valid=1 and stay unchanged until the next accepted request.
interface div_iter_nbit_if #(
    parameter int SIZE = 32
) ();

    logic            start;
    logic            is_signed;
    logic [SIZE-1:0] dividend;
    logic [SIZE-1:0] divisor;
    logic            ready;
    logic            valid;
    logic            error;
    logic [SIZE-1:0] quotient;
    logic [SIZE-1:0] remainder;

    modport master (
        output start, is_signed, dividend, divisor,
        input  ready, valid, error, quotient, remainder
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output ready, valid, error, quotient, remainder
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division stage retiring STEP quotient bits.
//   pr_in    : partial remainder entering the stage (SIZE+1 bits, always < divisor)
//   num_bits : next STEP dividend bits, MSB first
//   divisor  : divisor magnitude
//   pr_out   : partial remainder leaving the stage
//   q_bits   : STEP quotient bits, MSB first
module div_step #(
    parameter int SIZE = 32,
    parameter int STEP = 1
) (
    input  logic [SIZE:0]   pr_in,
    input  logic [STEP-1:0] num_bits,
    input  logic [SIZE-1:0] divisor,
    output logic [SIZE:0]   pr_out,
    output logic [STEP-1:0] q_bits
);

    logic [SIZE:0] pr_v;

    always_comb begin
        pr_v   = pr_in;
        q_bits = '0;
        for (int i = STEP - 1; i >= 0; i--) begin
            // The remainder is below the divisor, so its top bit is zero and the
            // shift cannot lose information; the extra bit holds the shifted value.
            pr_v = {pr_v[SIZE-1:0], num_bits[i]};
            if (pr_v >= {1'b0, divisor}) begin
                pr_v      = pr_v - {1'b0, divisor};
                q_bits[i] = 1'b1;
            end
        end
        pr_out = pr_v;
    end

endmodule

// File: rtl/div_iter_nbit.sv
// Iterative signed/unsigned divider, STEP quotient bits per clock.
//   clk, reset : clock and synchronous active-high reset
//   bus        : div_iter_nbit_if slave (start/is_signed/dividend/divisor in,
//                ready/valid/error/quotient/remainder out)
//   state_dbg  : current FSM state
// Magnitudes are divided MSB first by restoring division; signs are applied at
// the end (truncating division, remainder follows the dividend).
// Divide-by-zero gives quotient all-ones, remainder = dividend, error = 1.
// Signed most-negative / -1 gives quotient = dividend, remainder = 0.
// Build option DIV_EARLY_OUT_EN: those two cases skip CALC and report one cycle
// after accept; otherwise every request takes SIZE/STEP+1 cycles.
module div_iter_nbit
    import div_pkg::*;
#(
    parameter int SIZE = 32,
    parameter int STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    div_iter_nbit_if.slave   bus,
    output div_state_e       state_dbg
);

    localparam bit  CFG_OK = div_cfg_legal(SIZE, STEP);
    localparam int  ITER   = SIZE / STEP;
    localparam int  CW     = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $fatal(1, "div_iter_nbit: illegal SIZE/STEP combination");
        end
    endgenerate

    div_state_e      state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            accept, load_res;

    // Captured operation context.
    logic [SIZE:0]   pr;
    logic [SIZE-1:0] dq;      // dividend magnitude shifting out, quotient shifting in
    logic [SIZE-1:0] dvs;
    logic [SIZE-1:0] dvd;
    logic            neg_q, neg_r, div0, ovf;

    // Result registers.
    logic [SIZE-1:0] q_r, r_r;
    logic            err_r;

    // Request decode.
    logic            in_neg_a, in_neg_b, in_div0, in_ovf;
    logic [SIZE-1:0] in_mag_a, in_mag_b;

    assign accept   = bus.start && (state == ST_IDLE);
    assign in_neg_a = bus.is_signed && bus.dividend[SIZE-1];
    assign in_neg_b = bus.is_signed && bus.divisor[SIZE-1];
    // Negating the most-negative value yields the same bit pattern, which read
    // unsigned is exactly its magnitude 2^(SIZE-1).
    assign in_mag_a = in_neg_a ? -bus.dividend : bus.dividend;
    assign in_mag_b = in_neg_b ? -bus.divisor  : bus.divisor;
    assign in_div0  = (bus.divisor == '0);
    assign in_ovf   = bus.is_signed && (bus.dividend == {1'b1, {(SIZE-1){1'b0}}})
                      && (bus.divisor == '1);

    logic [SIZE:0]   pr_step;
    logic [STEP-1:0] q_step;
    logic [SIZE-1:0] dq_step;

    div_step #(
        .SIZE (SIZE),
        .STEP (STEP)
    ) u_step (
        .pr_in    (pr),
        .num_bits (dq[SIZE-1 -: STEP]),
        .divisor  (dvs),
        .pr_out   (pr_step),
        .q_bits   (q_step)
    );

    assign dq_step = {dq[SIZE-STEP-1:0], q_step};

    // Result formation. Results are loaded either from the last CALC iteration
    // (context from registers) or, with early-out, straight from the request.
    logic            f_div0, f_ovf, f_neg_q, f_neg_r;
    logic [SIZE-1:0] f_dvd, res_q, res_r;

    always_comb begin
        if (state == ST_IDLE) begin
            f_div0  = in_div0;
            f_ovf   = in_ovf;
            f_neg_q = in_neg_a ^ in_neg_b;
            f_neg_r = in_neg_a;
            f_dvd   = bus.dividend;
        end else begin
            f_div0  = div0;
            f_ovf   = ovf;
            f_neg_q = neg_q;
            f_neg_r = neg_r;
            f_dvd   = dvd;
        end
        if (f_div0) begin
            res_q = '1;
            res_r = f_dvd;
        end else if (f_ovf) begin
            res_q = f_dvd;
            res_r = '0;
        end else begin
            res_q = f_neg_q ? -dq_step : dq_step;
            res_r = f_neg_r ? -pr_step[SIZE-1:0] : pr_step[SIZE-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        load_res  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (in_div0 || in_ovf) begin
                        state_nxt = ST_DONE;
                        load_res  = 1'b1;
                    end
`endif
                end
            end
            ST_CALC: begin
                if (cnt == LAST) begin
                    state_nxt = ST_DONE;
                    load_res  = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            q_r   <= '0;
            r_r   <= '0;
            err_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_res) begin
                q_r   <= res_q;
                r_r   <= res_r;
                err_r <= f_div0;
            end
            if (accept) begin
                cnt <= '0;
            end else if (state == ST_CALC) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Operand context needs no reset: it is always reloaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            pr    <= '0;
            dq    <= in_mag_a;
            dvs   <= in_mag_b;
            dvd   <= bus.dividend;
            neg_q <= in_neg_a ^ in_neg_b;
            neg_r <= in_neg_a;
            div0  <= in_div0;
            ovf   <= in_ovf;
        end else if (state == ST_CALC) begin
            pr <= pr_step;
            dq <= dq_step;
        end
    end

    assign bus.ready     = (state == ST_IDLE);
    assign bus.valid     = (state == ST_DONE);
    assign bus.error     = err_r;
    assign bus.quotient  = q_r;
    assign bus.remainder = r_r;
    assign state_dbg     = state;

endmodule
